// File: rtl/noc_pkg.sv
// Shared NoC types and constants.
//   FLIT_W          : flit width in bits
//   ADDR_HI/ADDR_LO : destination address field inside a flit (passed through untouched)
//   flit_t          : raw flit
//   tagged_flit_t   : flit plus the index of the input it arrived on
package noc_pkg;

  localparam int unsigned FLIT_W  = 9;
  localparam int unsigned ADDR_HI = 8;
  localparam int unsigned ADDR_LO = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic  src;
    flit_t data;
  } tagged_flit_t;

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO for an arbitrary packed entry type.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   push_data_i  : entry to write
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : entry at the read pointer (all-zero after reset)
//   count_o      : current occupancy, 0..Depth
//   full_o       : count_o == Depth
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module flit_fifo #(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = logic [7:0]
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  entry_t                       push_data_i,
  input  logic                         pop_i,
  output entry_t                       head_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);

  entry_t          mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign push    = push_i && !full_o;
  assign pop     = pop_i && (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/merge2_rr.sv
// Two-input flit merge with round-robin arbitration into a small output FIFO.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in0_valid_i/in0_data_i     : input 0 flit, in0_ready_o accepts it this cycle
//   in1_valid_i/in1_data_i     : input 1 flit, in1_ready_o accepts it this cycle
//   out_valid_o/out_data_o     : FIFO head flit, out_src_o = input it came from
//   out_ready_i                : consumer takes the head flit
//   count_o                    : FIFO occupancy
// Ready never depends on out_ready_i: space is judged on the registered count only.
module merge2_rr
  import noc_pkg::*;
#(
  parameter int unsigned W     = FLIT_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in0_valid_i,
  input  logic [W-1:0]                 in0_data_i,
  output logic                         in0_ready_o,
  input  logic                         in1_valid_i,
  input  logic [W-1:0]                 in1_data_i,
  output logic                         in1_ready_o,
  output logic                         out_valid_o,
  output logic [W-1:0]                 out_data_o,
  output logic                         out_src_o,
  input  logic                         out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  // Same layout as tagged_flit_t, but sized by W so the block stays parameterisable.
  typedef struct packed {
    logic         src;
    logic [W-1:0] data;
  } entry_t;

  logic   prio_q, prio_d;
  logic   gnt0, gnt1;
  logic   fifo_full;
  entry_t push_data, head;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    // rst_n gate keeps both readies low for the whole reset window.
    if (rst_n && !fifo_full) begin
      if (in0_valid_i && (!in1_valid_i || !prio_q)) gnt0 = 1'b1;
      else if (in1_valid_i)                         gnt1 = 1'b1;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  assign push_data.src  = gnt1;
  assign push_data.data = gnt1 ? in1_data_i : in0_data_i;

  flit_fifo #(
    .Depth   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (gnt0 || gnt1),
    .push_data_i (push_data),
    .pop_i       (out_valid_o && out_ready_i),
    .head_o      (head),
    .count_o     (count_o),
    .full_o      (fifo_full)
  );

  assign in0_ready_o = gnt0;
  assign in1_ready_o = gnt1;
  assign out_valid_o = (count_o != '0);
  assign out_data_o  = head.data;
  assign out_src_o   = head.src;

endmodule

// File: tb/tb_merge2_rr.sv
module tb_merge2_rr;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH = 2 instance for directed tests
  logic       v0, v1, r0, r1, ov, os, ordy;
  logic [8:0] d0, d1, od;
  logic [1:0] cnt;

  // DEPTH = 4 instance for the soak
  logic       v0_4, v1_4, r0_4, r1_4, ov_4, os_4, ordy_4;
  logic [8:0] d0_4, d1_4, od_4;
  logic [2:0] cnt_4;

  int n_checks = 0;
  int n_fail   = 0;

  merge2_rr #(.W(9), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid_i(v0), .in0_data_i(d0), .in0_ready_o(r0),
    .in1_valid_i(v1), .in1_data_i(d1), .in1_ready_o(r1),
    .out_valid_o(ov), .out_data_o(od), .out_src_o(os), .out_ready_i(ordy),
    .count_o(cnt)
  );

  merge2_rr #(.W(9), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in0_valid_i(v0_4), .in0_data_i(d0_4), .in0_ready_o(r0_4),
    .in1_valid_i(v1_4), .in1_data_i(d1_4), .in1_ready_o(r1_4),
    .out_valid_o(ov_4), .out_data_o(od_4), .out_src_o(os_4), .out_ready_i(ordy_4),
    .count_o(cnt_4)
  );

  // Scoreboard for the DEPTH=2 instance: {src,data} in global accept order.
  logic [9:0] exp_q [$];
  // Scoreboards for the DEPTH=4 instance: per-input order.
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  // Signals are stable at the falling edge; record transfers due at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      q0.delete();
      q1.delete();
    end else begin
      if (ov && ordy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_pop: got src=%0b data=%h, required no output", os, od);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({os, od} !== e) begin
            n_fail++;
            $display("FAIL sb_pop: got src=%0b data=%h, required src=%0b data=%h",
                     os, od, e[9], e[8:0]);
          end
        end
      end
      if (v0 && r0) exp_q.push_back({1'b0, d0});
      if (v1 && r1) exp_q.push_back({1'b1, d1});

      if (ov_4 && ordy_4) begin
        logic [8:0] e4;
        n_checks++;
        if ((os_4 ? q1.size() : q0.size()) == 0) begin
          n_fail++;
          $display("FAIL soak_pop: got src=%0b data=%h, required nothing queued", os_4, od_4);
        end else begin
          e4 = os_4 ? q1.pop_front() : q0.pop_front();
          if (od_4 !== e4) begin
            n_fail++;
            $display("FAIL soak_pop: src=%0b got data=%h, required %h", os_4, od_4, e4);
          end
        end
      end
      if (v0_4 && r0_4) q0.push_back(d0_4);
      if (v1_4 && r1_4) q1.push_back(d1_4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
    repeat (n) step();
  endtask

  task automatic test_reset();
    v0 = 1'b1; d0 = 9'h10A; v1 = 1'b1; d1 = 9'h1F5; ordy = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({r0, r1, ov, os, od, cnt} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_state: got r0=%0b r1=%0b ov=%0b os=%0b od=%h cnt=%0d, required all 0",
               r0, r1, ov, os, od, cnt);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL first_grant: got r0=%0b r1=%0b, required r0=1 r1=0", r0, r1);
    end
    step();
    n_checks++;
    if (ov !== 1'b1 || od !== 9'h10A || os !== 1'b0 || cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL first_out: got ov=%0b od=%h os=%0b cnt=%0d, required 1 10a 0 1",
               ov, od, os, cnt);
    end
    ordy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      n_checks++;
      if (r0 !== (i % 2 == 0) || r1 !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL alternate[%0d]: got r0=%0b r1=%0b, required r0=%0b r1=%0b",
                 i, r0, r1, (i % 2 == 0), (i % 2 == 1));
      end
      step();
    end
    drain(4);
  endtask

  task automatic test_single_input();
    logic [8:0] pat [3];
    pat[0] = 9'h021; pat[1] = 9'h022; pat[2] = 9'h023;
    v0 = 1'b0; v1 = 1'b1; ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d1 = pat[i];
      #1;
      n_checks++;
      if (r1 !== 1'b1 || r0 !== 1'b0) begin
        n_fail++;
        $display("FAIL single_in1[%0d]: got r1=%0b r0=%0b, required r1=1 r0=0", i, r1, r0);
      end
      step();
    end
    // prio must now favour in0; no edge passes, so nothing is accepted.
    v0 = 1'b1; d0 = 9'h0EE;
    #1;
    n_checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_after_in1: got r0=%0b r1=%0b, required r0=1 r1=0", r0, r1);
    end
    v0 = 1'b0; v1 = 1'b0;
    drain(4);
  endtask

  task automatic test_full();
    ordy = 1'b0;
    v0 = 1'b1; d0 = 9'h0AA; step();
    d0 = 9'h0BB; step();
    d0 = 9'h0CC; v1 = 1'b1; d1 = 9'h0DD;
    #1;
    n_checks++;
    if (cnt !== 2'd2 || r0 !== 1'b0 || r1 !== 1'b0 || od !== 9'h0AA) begin
      n_fail++;
      $display("FAIL full_state: got cnt=%0d r0=%0b r1=%0b od=%h, required 2 0 0 0aa",
               cnt, r0, r1, od);
    end
    ordy = 1'b1;
    #1;
    n_checks++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin
      n_fail++;
      $display("FAIL no_passthrough: got r0=%0b r1=%0b, required 0 0", r0, r1);
    end
    step();
    ordy = 1'b0;
    #1;
    n_checks++;
    if (cnt !== 2'd1 || od !== 9'h0BB || r1 !== 1'b1 || r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL after_pop: got cnt=%0d od=%h r1=%0b r0=%0b, required 1 0bb 1 0",
               cnt, od, r1, r0);
    end
    step();
    v0 = 1'b0; v1 = 1'b0;
    #1;
    n_checks++;
    if (cnt !== 2'd2) begin
      n_fail++;
      $display("FAIL refill: got cnt=%0d, required 2", cnt);
    end
    drain(5);
  endtask

  task automatic test_backpressure();
    logic [2:0] pat;
    pat = 3'b100;
    v0 = 1'b1; d0 = 9'h155; ordy = 1'b0;
    step();
    v0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ordy = pat[i];
      #1;
      n_checks++;
      if (ov !== 1'b1 || od !== 9'h155 || os !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ov=%0b od=%h os=%0b, required 1 155 0", i, ov, od, os);
      end
      step();
    end
    n_checks++;
    if (ov !== 1'b0 || cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL after_hold_pop: got ov=%0b cnt=%0d, required 0 0", ov, cnt);
    end
    ordy = 1'b0;
  endtask

  task automatic test_async_reset();
    ordy = 1'b0;
    v0 = 1'b1; d0 = 9'h033; step();
    d0 = 9'h044; step();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov !== 1'b0 || cnt !== 2'd0 || od !== 9'h000 || r0 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ov=%0b cnt=%0d od=%h r0=%0b, required 0 0 000 0",
               ov, cnt, od, r0);
    end
    repeat (2) step();
    v0 = 1'b0; ordy = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_empty[%0d]: got ov=%0b od=%h, required ov=0", i, ov, od);
      end
      step();
    end
  endtask

  task automatic test_soak();
    logic [8:0] seq0, seq1;
    logic       a0, a1;
    int         g0, g1;
    bit         fair;
    seq0 = 9'd0; seq1 = 9'h100; g0 = 0; g1 = 0;
    v0_4 = 1'b0; v1_4 = 1'b0; d0_4 = seq0; d1_4 = seq1; ordy_4 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      fair = (c >= 8000);
      @(negedge clk);
      a0 = v0_4 && r0_4;
      a1 = v1_4 && r1_4;
      if (fair) begin
        if (a0) g0++;
        if (a1) g1++;
      end
      @(posedge clk);
      #1;
      if (a0) seq0 = seq0 + 9'd1;
      if (a1) seq1 = seq1 + 9'd1;
      // A flit, once offered, stays offered unchanged until accepted.
      if (!v0_4 || a0) v0_4 = fair ? 1'b1 : 1'($urandom_range(0, 1));
      if (!v1_4 || a1) v1_4 = fair ? 1'b1 : 1'($urandom_range(0, 1));
      d0_4 = seq0;
      d1_4 = seq1;
      ordy_4 = 1'($urandom_range(0, 3) != 0);
    end
    v0_4 = 1'b0; v1_4 = 1'b0; ordy_4 = 1'b1;
    for (int i = 0; i < 20 && ov_4; i++) step();
    repeat (2) step();
    n_checks++;
    if (ov_4 !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL soak_drain: got ov=%0b left0=%0d left1=%0d, required 0 0 0",
               ov_4, q0.size(), q1.size());
    end
    n_checks++;
    if (g0 - g1 > 1 || g1 - g0 > 1 || g0 + g1 < 100) begin
      n_fail++;
      $display("FAIL fairness: got g0=%0d g1=%0d, required |g0-g1|<=1 with traffic", g0, g1);
    end
  endtask

  initial begin
    v0 = 0; v1 = 0; d0 = 0; d1 = 0; ordy = 0;
    v0_4 = 0; v1_4 = 0; d0_4 = 0; d1_4 = 0; ordy_4 = 0;
    test_reset();
    test_single_input();
    test_full();
    test_backpressure();
    test_async_reset();
    test_soak();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending flits, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/merge2_rr.md
# merge2_rr

Two-input, one-output flit merge with round-robin arbitration and a small output FIFO, clocked and synchronous to a single clock. It sits directly downstream of the 2-way leaf decoders in the NoC router. Wherever two routed paths converge on one link, it consumes the decoder output branches and merges them onto one channel. It tags each output flit with the input it came from.

## Interface
Parameters:
- W, 9, flit width; bits [8:5] carry the destination address, unchanged by this block.
- DEPTH, 2, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in0_valid  in  1  input 0 has a flit.
- in0_data  in  W  input 0 flit.
- in0_ready  out  1  input 0 flit is accepted this cycle.
- in1_valid  in  1  input 1 has a flit.
- in1_data  in  W  input 1 flit.
- in1_ready  out  1  input 1 flit is accepted this cycle.
- out_valid  out  1  FIFO head is valid.
- out_data  out  W  FIFO head flit.
- out_src  out  1  source of the head flit: 0 = in0, 1 = in1.
- out_ready  in  1  consumer takes the head flit.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Transfers:
  - A transfer on inX happens on a cycle where inX_valid && inX_ready.
  - A transfer on out happens on a cycle where out_valid && out_ready.
- Space: the FIFO has space when count < DEPTH. There is no same-cycle pass-through when full; a pop does not free space until the next cycle.
- Arbitration (combinational, at most one grant per cycle). A 1-bit priority register prio selects which input wins a tie.
  - No space: no grant; both ready signals are 0.
  - One input valid: that input is granted.
  - Both inputs valid: input prio is granted.
  - Exactly one inX_ready is asserted when there is space and at least one input is valid. The ready of the losing input is 0.
- Priority update: on any accepted input transfer, prio is set to the non-granted input (grant 0 sets prio to 1, and vice versa). This applies even when only one input was valid. With no transfer, prio holds.
- FIFO:
  - Each entry stores {src, data}; W+1 bits.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Push on an input transfer; pop on an output transfer.
- Occupancy:
  - count increments on push only.
  - count decrements on pop only.
  - count is unchanged on simultaneous push and pop.
- Outputs:
  - out_valid = (count != 0).
  - out_data and out_src are driven from the entry at the read pointer.
  - They must hold stable while out_valid && !out_ready.
- Flits are never dropped, duplicated, reordered within one input, or modified.

## Timing
- Reset (asynchronous assert, synchronous release to clk):
  - count = 0, both pointers = 0, prio = 0, all FIFO entries = 0.
  - out_valid = 0, out_data = 0, out_src = 0.
  - in0_ready = in1_ready = 0 while rst_n is low.
- Reset mid-operation: all stored flits are discarded with no output transfer. The first cycle after release behaves as an empty FIFO with prio = 0.
- Latency: a flit accepted at edge N drives out_valid at the output after edge N; consumption is possible from cycle N+1 at the earliest.
- Throughput: 1 flit/cycle sustained when out_ready is held high and DEPTH ≥ 2.
- Ready paths: inX_ready depends combinationally on inX_valid, the other input's valid, prio and count. It never depends on out_ready.
- Valid rule: input valid may not depend on ready.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.

## Structure
- Shared package noc_pkg holds:
  - FLIT_W = 9, ADDR_HI = 8, ADDR_LO = 5.
  - typedef flit_t (logic [FLIT_W-1:0]).
  - typedef struct packed tagged_flit_t {logic src; flit_t data;}.
- Sub-module flit_fifo, parameterised on DEPTH and the entry type. It provides the push/pop interface, count and head output.
- merge2_rr contains only the arbiter, the prio register and a flit_fifo instance.

## Test plan
- Reset with both inputs valid (in0 = 9'h10A, in1 = 9'h1F5), then release:
  - Cycle 1 grants in0.
  - Output order: 9'h10A (src 0), then 9'h1F5 (src 1).
  - The two inputs alternate from then on.
- Only in1 valid for 3 flits (9'h021, 9'h022, 9'h023), out_ready = 1:
  - All three are accepted back-to-back with src = 1.
  - prio = 0 afterwards.
- Full FIFO:
  - Setup: out_ready = 0, push 9'h0AA then 9'h0BB; count = 2, both ready = 0.
  - Hold out_ready = 1 for one cycle: out_data = 9'h0AA pops.
  - The next accept occurs one cycle later, not the same cycle.
- Backpressure stability: head 9'h155, out_ready toggles 0,0,1 → out_data/out_src stay 9'h155/src unchanged until the pop cycle.
- Assert rst_n low while count = 2 → out_valid = 0 and count = 0 immediately (asynchronous); the stored flits never appear at the output.
- Random valid/ready soak, 10k cycles, DEPTH = 4:
  - Per-input order is preserved and no flits are lost.
  - With both inputs continuously valid, the grant counts of the two inputs differ by ≤ 1.
